fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch_pkg.sv | 18 +
 rtl/fetch_prefetch_if.sv | 34 +++
 rtl/fetch_prefetch_sync_fifo.sv | 70 +++++++
 rtl/fetch_prefetch.sv | 94 +++++++++
 tb/tb_fetch_prefetch.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared fetch-control definitions: FSM encoding, memory access sizes, PC step.
package fetch_prefetch_pkg;

  // Fetch sequencer states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Memory access size codes
  localparam logic [1:0] ACC_SIZE_WORD = 2'b00;
  localparam logic [1:0] ACC_SIZE_HALF = 2'b01;
  localparam logic [1:0] ACC_SIZE_BYTE = 2'b10;

  // Byte distance between consecutive instruction words
  localparam int unsigned PC_INC = 4;

endpackage : fetch_prefetch_pkg

// File: rtl/fetch_prefetch_if.sv
// Memory-side request/response and decode-side instruction handshake.
interface fetch_prefetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_acc_size;
  logic              mem_busy;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] insn_out;
  logic [ADDR_W-1:0] pc_out;
  logic              insn_valid;
  logic              insn_ready;

  // Fetch unit view
  modport master (
    output mem_req, mem_addr, mem_acc_size,
    input  mem_busy, mem_rdata,
    output insn_out, pc_out, insn_valid,
    input  insn_ready
  );

  // Memory / decode environment view
  modport slave (
    input  mem_req, mem_addr, mem_acc_size,
    output mem_busy, mem_rdata,
    input  insn_out, pc_out, insn_valid,
    output insn_ready
  );

endinterface : fetch_prefetch_if

// File: rtl/fetch_prefetch_sync_fifo.sv
// Prefetch queue: power-of-two circular buffer with flush and registered occupancy.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  // Guard against push-when-full and pop-when-empty
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop cancel out
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage, pointers and occupancy; storage cleared on reset so the head reads zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

endmodule : sync_fifo

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: issues sequential word reads, queues returned words
// with their PCs, and flushes on branch/jump redirect.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       DEPTH         = 4,
  parameter logic [ADDR_W-1:0] START_ADDRESS = ADDR_W'(32'h8002_0000)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] level,
  fetch_prefetch_if.master       bus
);

  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              inflight;
  logic              accept;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic [LVL_W-1:0]  occupancy;
  logic [ENTRY_W-1:0] head;

  // Issue credit counts queued words plus the one response still on its way
  assign occupancy        = level + LVL_W'(inflight);
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // Request is withheld during a redirect so the old stream stops immediately
  assign bus.mem_req      = (state == ST_RUN) && enable && !redirect_valid
                            && (occupancy < LVL_W'(DEPTH));
  assign bus.mem_addr     = fetch_pc;
  assign bus.mem_acc_size = ACC_SIZE_WORD;
  assign accept           = bus.mem_req && !bus.mem_busy;

  // Redirect squashes the response arriving now and blocks decode consumption
  assign push = inflight && !redirect_valid;
  assign pop  = head_valid && bus.insn_ready && !redirect_valid;

  assign bus.insn_valid = head_valid;
  assign bus.insn_out   = head[DATA_W-1:0];
  assign bus.pc_out     = head[ENTRY_W-1:DATA_W];

  // Sequencer: run/idle state, fetch PC and in-flight tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      fetch_pc    <= START_ADDRESS;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enable)  state <= ST_RUN;
        ST_RUN:  if (!enable) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      inflight <= accept;
      if (accept) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(PC_INC);
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
      end
    end
  end

  // Queue of {pc, instruction} pairs toward decode
  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({inflight_pc, bus.mem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (level),
    .valid     (head_valid)
  );

endmodule : fetch_prefetch

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a one-cycle-latency memory model.
module tb_fetch_prefetch;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  level;

  int n_checks;
  int n_pass;

  fetch_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_prefetch dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .level          (level),
    .bus            (bus)
  );

  always #5 clock = ~clock;

  // Memory content: each word is a fixed scramble of its address
  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1; enable = 1'b0; bus.insn_ready = 1'b0; bus.mem_busy = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Memory: accepted request sampled mid-cycle, data presented for the following cycle
  initial begin : mem_model
    logic        acc;
    logic [31:0] a;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      acc = bus.mem_req && !bus.mem_busy;
      a   = bus.mem_addr;
      @(posedge clock);
      #1;
      bus.mem_rdata = acc ? insn_of(a) : 32'hDEAD_BEEF;
    end
  end

  initial begin
    clock = 1'b0; reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.mem_busy = 1'b0; bus.insn_ready = 1'b0;
    n_checks = 0; n_pass = 0;

    // Sequential streaming
    do_reset();
    enable = 1'b1; bus.insn_ready = 1'b1; #1;
    check("rst_level", level, 0);
    check("rst_valid", bus.insn_valid, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_insn", bus.insn_out, 0);
    check("rst_pc", bus.pc_out, 0);
    check("rst_addr", bus.mem_addr, 32'h8002_0000);
    check("acc_size", bus.mem_acc_size, 0);
    cyc(); #1;
    check("s1_req", bus.mem_req, 1);
    check("s1_addr", bus.mem_addr, 32'h8002_0000);
    check("s1_valid", bus.insn_valid, 0);
    cyc(); #1;
    check("s2_addr", bus.mem_addr, 32'h8002_0004);
    check("s2_valid", bus.insn_valid, 0);
    cyc(); #1;
    check("s3_valid", bus.insn_valid, 1);
    check("s3_pc", bus.pc_out, 32'h8002_0000);
    check("s3_insn", bus.insn_out, insn_of(32'h8002_0000));
    check("s3_addr", bus.mem_addr, 32'h8002_0008);
    cyc(); #1;
    check("s4_pc", bus.pc_out, 32'h8002_0004);
    check("s4_insn", bus.insn_out, insn_of(32'h8002_0004));
    check("s4_level", level, 1);
    cyc(); #1;
    check("s5_pc", bus.pc_out, 32'h8002_0008);

    // Decode stall fills the queue, then drains in order
    do_reset();
    enable = 1'b1; bus.insn_ready = 1'b0;
    repeat (9) cyc();
    #1;
    check("full_level", level, 4);
    check("full_req", bus.mem_req, 0);
    check("full_addr", bus.mem_addr, 32'h8002_0010);
    check("full_pc", bus.pc_out, 32'h8002_0000);
    cyc(); bus.insn_ready = 1'b1; #1;
    check("full_req_pop", bus.mem_req, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin cyc(); #1; end
      check("drain_valid", bus.insn_valid, 1);
      check("drain_pc", bus.pc_out, 32'h8002_0000 + 32'(4 * i));
      check("drain_insn", bus.insn_out, insn_of(32'h8002_0000 + 32'(4 * i)));
      if (i == 1) begin
        check("drain_level1", level, 3);
        check("drain_addr1", bus.mem_addr, 32'h8002_0010);
      end
      if (i == 2) check("drain_level2", level, 2);
    end

    // Redirect with a response in flight
    do_reset();
    enable = 1'b1; bus.insn_ready = 1'b1;
    cyc(); cyc(); cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h8002_0103; #1;
    check("redir_req", bus.mem_req, 0);
    cyc(); redirect_valid = 1'b0; #1;
    check("redir_level", level, 0);
    check("redir_valid", bus.insn_valid, 0);
    check("redir_req_next", bus.mem_req, 1);
    check("redir_addr", bus.mem_addr, 32'h8002_0100);
    cyc(); #1;
    check("redir_valid2", bus.insn_valid, 0);
    cyc(); #1;
    check("redir_valid3", bus.insn_valid, 1);
    check("redir_pc", bus.pc_out, 32'h8002_0100);
    check("redir_insn", bus.insn_out, insn_of(32'h8002_0100));

    // Memory busy for three cycles
    do_reset();
    enable = 1'b1; bus.insn_ready = 1'b1;
    cyc();
    cyc(); bus.mem_busy = 1'b1; #1;
    check("busy1_req", bus.mem_req, 1);
    check("busy1_addr", bus.mem_addr, 32'h8002_0004);
    cyc(); #1;
    check("busy2_addr", bus.mem_addr, 32'h8002_0004);
    cyc(); #1;
    check("busy3_addr", bus.mem_addr, 32'h8002_0004);
    check("busy3_valid", bus.insn_valid, 0);
    cyc(); bus.mem_busy = 1'b0; #1;
    check("resume_addr", bus.mem_addr, 32'h8002_0004);
    cyc(); #1;
    check("resume_next", bus.mem_addr, 32'h8002_0008);
    cyc(); #1;
    check("resume_pc1", bus.pc_out, 32'h8002_0004);
    check("resume_valid", bus.insn_valid, 1);
    cyc(); #1;
    check("resume_pc2", bus.pc_out, 32'h8002_0008);
    check("resume_valid2", bus.insn_valid, 1);

    // Address wrap at the top of the space
    do_reset();
    enable = 1'b1; bus.insn_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    check("wrap_req0", bus.mem_req, 0);
    cyc(); redirect_valid = 1'b0; #1;
    check("wrap_addr0", bus.mem_addr, 32'hFFFF_FFFC);
    check("wrap_req", bus.mem_req, 1);
    cyc(); #1;
    check("wrap_addr1", bus.mem_addr, 32'h0000_0000);
    cyc(); #1;
    check("wrap_pc0", bus.pc_out, 32'hFFFF_FFFC);
    cyc(); #1;
    check("wrap_pc1", bus.pc_out, 32'h0000_0000);
    check("wrap_insn1", bus.insn_out, insn_of(32'h0000_0000));

    // Reset mid-operation with three queued and one in flight
    do_reset();
    enable = 1'b1; bus.insn_ready = 1'b0;
    repeat (5) cyc();
    reset = 1'b1; #1;
    check("mid_level", level, 3);
    cyc(); reset = 1'b0; bus.insn_ready = 1'b1; #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", bus.insn_valid, 0);
    check("mid_rst_req", bus.mem_req, 0);
    check("mid_rst_insn", bus.insn_out, 0);
    check("mid_rst_pc", bus.pc_out, 0);
    check("mid_rst_addr", bus.mem_addr, 32'h8002_0000);
    cyc(); #1;
    check("mid_drop_level", level, 0);
    check("mid_req", bus.mem_req, 1);
    cyc(); #1;
    check("mid_drop_valid", bus.insn_valid, 0);
    cyc(); #1;
    check("mid_restart_valid", bus.insn_valid, 1);
    check("mid_restart_pc", bus.pc_out, 32'h8002_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_prefetch
